// File: rtl/eq_mix_pkg.sv
// Shared types and helpers for the EQ band mixer.
//   SMPL_W : audio sample width (signed)
//   POT_W  : band gain / volume control width (unsigned)
//   state_t: mixer sequencing states
//   sat16  : clamp a wide signed value to the 16-bit sample range
package eq_mix_pkg;

  localparam int unsigned SMPL_W   = 16;
  localparam int unsigned POT_W    = 12;
  localparam int unsigned SAT_IN_W = 48;

  typedef enum logic [1:0] {IDLE, ACC, VOL, OUT} state_t;

  localparam logic signed [SAT_IN_W-1:0] SAT_MAX = 48'sd32767;
  localparam logic signed [SAT_IN_W-1:0] SAT_MIN = -48'sd32768;

  function automatic logic signed [SMPL_W-1:0] sat16(input logic signed [SAT_IN_W-1:0] x);
    if (x > SAT_MAX)      return 16'sh7FFF;
    else if (x < SAT_MIN) return 16'sh8000;
    else                  return x[SMPL_W-1:0];
  endfunction

endpackage

// File: rtl/eq_band_mac.sv
// One channel of the band mixer: per-band gain multiply, arithmetic shift and
// accumulate, then master volume scaling and a single saturation to 16 bits.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_clr      : clear accumulator (new sample accepted)
//   i_acc_en   : add the current band term into the accumulator
//   i_vol_en   : apply volume, saturate and register o_aud
//   i_band     : signed band sample selected for this cycle
//   i_pot      : unsigned band gain for this cycle
//   i_vol      : unsigned effective master volume
//   o_aud      : registered saturated output sample
module eq_band_mac
  import eq_mix_pkg::*;
#(
  parameter int unsigned NUM_BANDS  = 5,
  parameter int unsigned GAIN_SHIFT = 11,
  parameter int unsigned VOL_SHIFT  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_acc_en,
  input  logic                     i_vol_en,
  input  logic signed [SMPL_W-1:0] i_band,
  input  logic        [POT_W-1:0]  i_pot,
  input  logic        [POT_W-1:0]  i_vol,
  output logic signed [SMPL_W-1:0] o_aud
);

  localparam int unsigned PROD_W  = SMPL_W + POT_W + 1;
  localparam int unsigned TERM_W  = PROD_W - GAIN_SHIFT;
  localparam int unsigned ACC_W   = TERM_W + $clog2(NUM_BANDS) + 1;
  localparam int unsigned VPROD_W = ACC_W + POT_W + 1;

  logic signed [POT_W:0]     w_pot_s;
  logic signed [POT_W:0]     w_vol_s;
  logic signed [PROD_W-1:0]  w_band_x;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [TERM_W-1:0]  w_term;
  logic signed [VPROD_W-1:0] w_acc_x;
  logic signed [VPROD_W-1:0] w_vprod;
  logic signed [ACC_W-1:0]   r_acc;

  // Gains are unsigned; a zero MSB makes them non-negative signed operands.
  assign w_pot_s  = {1'b0, i_pot};
  assign w_vol_s  = {1'b0, i_vol};
  assign w_band_x = PROD_W'(i_band);
  assign w_prod   = w_band_x * PROD_W'(w_pot_s);
  assign w_term   = TERM_W'(w_prod >>> GAIN_SHIFT);
  assign w_acc_x  = VPROD_W'(r_acc);
  assign w_vprod  = w_acc_x * VPROD_W'(w_vol_s);

  // Band accumulator; no intermediate saturation, width covers all bands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_acc <= '0;
    else if (i_clr)    r_acc <= '0;
    else if (i_acc_en) r_acc <= r_acc + ACC_W'(w_term);
  end

  // Volume stage and the only saturation point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        o_aud <= '0;
    else if (i_vol_en) o_aud <= sat16(SAT_IN_W'(w_vprod >>> VOL_SHIFT));
  end

endmodule

// File: rtl/eq_band_mixer.sv
// Parametrised EQ summing stage: NUM_BANDS band samples per channel are scaled
// by per-band gain POTs through one MAC lane per channel (one band per clock),
// then master volume and 16-bit saturation are applied.
// Optional feature macro: EQ_VOL_SMOOTH_EN -- ramp the effective volume toward
// the requested volume by at most VOL_STEP per accepted sample.
// Ports:
//   clk, rst_n               : clock, async active-low reset
//   smpl_vld                 : new band set, accepted when not busy
//   band_lft / band_rght     : signed band samples, band i at [16*i +: 16]
//   pot                      : unsigned band gains, band i at [12*i +: 12]
//   volume                   : unsigned master volume
//   aud_out_lft/aud_out_rght : registered saturated outputs
//   out_vld                  : one-cycle pulse when outputs update
//   busy                     : high from acceptance until the out_vld cycle
//   ovr_err                  : one-cycle pulse, sample dropped while busy
module eq_band_mixer
  import eq_mix_pkg::*;
#(
  parameter int unsigned NUM_BANDS  = 5,
  parameter int unsigned GAIN_SHIFT = 11,
  parameter int unsigned VOL_SHIFT  = 12,
  parameter int unsigned VOL_STEP   = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            smpl_vld,
  input  logic [SMPL_W*NUM_BANDS-1:0]     band_lft,
  input  logic [SMPL_W*NUM_BANDS-1:0]     band_rght,
  input  logic [POT_W*NUM_BANDS-1:0]      pot,
  input  logic [POT_W-1:0]                volume,
  output logic signed [SMPL_W-1:0]        aud_out_lft,
  output logic signed [SMPL_W-1:0]        aud_out_rght,
  output logic                            out_vld,
  output logic                            busy,
  output logic                            ovr_err
);

  localparam int unsigned IDX_W = $clog2(NUM_BANDS);

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic                          w_accept;
  logic                          w_last;
  logic [IDX_W-1:0]              r_idx;
  logic [SMPL_W*NUM_BANDS-1:0]   r_band_lft;
  logic [SMPL_W*NUM_BANDS-1:0]   r_band_rght;
  logic [POT_W*NUM_BANDS-1:0]    r_pot;
  logic [POT_W-1:0]              r_vol_eff;
  logic [POT_W-1:0]              w_vol_nxt;
  logic signed [SMPL_W-1:0]      w_band_l;
  logic signed [SMPL_W-1:0]      w_band_r;
  logic [POT_W-1:0]              w_pot_sel;

  assign w_last = (r_idx == IDX_W'(NUM_BANDS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state; OUT accepts a new sample directly so there is no bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: if (smpl_vld) begin
        w_accept    = 1'b1;
        w_state_nxt = ACC;
      end
      ACC:  if (w_last) w_state_nxt = VOL;
      VOL:  w_state_nxt = OUT;
      OUT: begin
        if (smpl_vld) begin
          w_accept    = 1'b1;
          w_state_nxt = ACC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef EQ_VOL_SMOOTH_EN
  logic [POT_W-1:0] w_vol_diff;

  // Move toward the requested volume by at most VOL_STEP.
  always_comb begin
    w_vol_diff = '0;
    w_vol_nxt  = r_vol_eff;
    if (volume >= r_vol_eff) begin
      w_vol_diff = volume - r_vol_eff;
      if (32'(w_vol_diff) > VOL_STEP) w_vol_nxt = r_vol_eff + POT_W'(VOL_STEP);
      else                            w_vol_nxt = volume;
    end else begin
      w_vol_diff = r_vol_eff - volume;
      if (32'(w_vol_diff) > VOL_STEP) w_vol_nxt = r_vol_eff - POT_W'(VOL_STEP);
      else                            w_vol_nxt = volume;
    end
  end
`else
  assign w_vol_nxt = volume;
`endif

  // Band index counter and input capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_band_lft  <= '0;
      r_band_rght <= '0;
      r_pot       <= '0;
      r_vol_eff   <= '0;
    end else if (w_accept) begin
      r_idx       <= '0;
      r_band_lft  <= band_lft;
      r_band_rght <= band_rght;
      r_pot       <= pot;
      r_vol_eff   <= w_vol_nxt;
    end else if (r_state == ACC) begin
      r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Handshake flags, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      busy    <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      out_vld <= (w_state_nxt == OUT);
      busy    <= (w_state_nxt == ACC) || (w_state_nxt == VOL);
      ovr_err <= smpl_vld && ((r_state == ACC) || (r_state == VOL));
    end
  end

  // Select the current band for both lanes.
  always_comb begin
    w_band_l  = '0;
    w_band_r  = '0;
    w_pot_sel = '0;
    for (int i = 0; i < int'(NUM_BANDS); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_band_l  = r_band_lft[SMPL_W*i +: SMPL_W];
        w_band_r  = r_band_rght[SMPL_W*i +: SMPL_W];
        w_pot_sel = r_pot[POT_W*i +: POT_W];
      end
    end
  end

  eq_band_mac #(
    .NUM_BANDS (NUM_BANDS),
    .GAIN_SHIFT(GAIN_SHIFT),
    .VOL_SHIFT (VOL_SHIFT)
  ) u_mac_lft (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_accept),
    .i_acc_en(r_state == ACC),
    .i_vol_en(r_state == VOL),
    .i_band  (w_band_l),
    .i_pot   (w_pot_sel),
    .i_vol   (r_vol_eff),
    .o_aud   (aud_out_lft)
  );

  eq_band_mac #(
    .NUM_BANDS (NUM_BANDS),
    .GAIN_SHIFT(GAIN_SHIFT),
    .VOL_SHIFT (VOL_SHIFT)
  ) u_mac_rght (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_accept),
    .i_acc_en(r_state == ACC),
    .i_vol_en(r_state == VOL),
    .i_band  (w_band_r),
    .i_pot   (w_pot_sel),
    .i_vol   (r_vol_eff),
    .o_aud   (aud_out_rght)
  );

endmodule

// File: tb/tb_eq_band_mixer.sv
// Directed bench for eq_band_mixer at default parameters (5 bands, volume
// smoothing disabled). Expected outputs are hand-computed constants.
module tb_eq_band_mixer;

  localparam int NB = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            smpl_vld = 1'b0;
  logic [16*NB-1:0] band_lft = '0;
  logic [16*NB-1:0] band_rght = '0;
  logic [12*NB-1:0] pot = '0;
  logic [11:0]     volume = '0;
  logic [15:0]     aud_out_lft;
  logic [15:0]     aud_out_rght;
  logic            out_vld;
  logic            busy;
  logic            ovr_err;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_vld  = 0;

  always #5 clk = ~clk;

  eq_band_mixer #(.NUM_BANDS(NB)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .smpl_vld    (smpl_vld),
    .band_lft    (band_lft),
    .band_rght   (band_rght),
    .pot         (pot),
    .volume      (volume),
    .aud_out_lft (aud_out_lft),
    .aud_out_rght(aud_out_rght),
    .out_vld     (out_vld),
    .busy        (busy),
    .ovr_err     (ovr_err)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_vld) n_vld <= n_vld + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16*NB-1:0] rep16(input logic [15:0] v);
    logic [16*NB-1:0] r;
    for (int i = 0; i < NB; i++) r[16*i +: 16] = v;
    return r;
  endfunction

  function automatic logic [12*NB-1:0] rep12(input logic [11:0] v);
    logic [12*NB-1:0] r;
    for (int i = 0; i < NB; i++) r[12*i +: 12] = v;
    return r;
  endfunction

  // Waits (bounded) at negedges for out_vld; c is the cycle count when seen.
  task automatic wait_vld(output int c, output bit ok);
    c  = -1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_vld) begin
        ok = 1'b1;
        c  = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One sample: latency counted in rising edges from driving smpl_vld
  // (the accepting edge is the first) through the out_vld cycle.
  task automatic run(input string tag, input logic [16*NB-1:0] bl, input logic [16*NB-1:0] br,
                     input logic [12*NB-1:0] p, input logic [11:0] v,
                     input logic [15:0] el, input logic [15:0] er);
    int  start;
    int  c;
    bit  ok;
    @(negedge clk);
    band_lft = bl; band_rght = br; pot = p; volume = v;
    smpl_vld = 1'b1;
    start = cyc;
    @(negedge clk);
    smpl_vld = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_vld(c, ok);
    chk({tag, "_timeout"}, 32'(ok), 32'd1);
    chk({tag, "_latency"}, 32'(c - start), 32'd7);
    chk({tag, "_busy_at_vld"}, 32'(busy), 32'd0);
    chk({tag, "_lft"}, 32'(aud_out_lft), 32'(el));
    chk({tag, "_rght"}, 32'(aud_out_rght), 32'(er));
  endtask

  initial begin
    int  c0;
    int  c1;
    int  v0;
    int  start;
    bit  ok;
    logic [12*NB-1:0] pmix;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_lft", 32'(aud_out_lft), 32'h0);
    chk("rst_rght", 32'(aud_out_rght), 32'h0);
    chk("rst_vld", 32'(out_vld), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovr", 32'(ovr_err), 32'h0);
    rst_n = 1'b1;

    // Unity gains: 5*4096 = 20480, *4095>>12 = 20475 (0x4FFB); mirror is -20475
    run("unity", rep16(16'h1000), rep16(16'hF000), rep12(12'h800), 12'hFFF, 16'h4FFB, 16'hB005);

    // Saturation on both rails
    run("sat", rep16(16'h7000), rep16(16'h8000), rep12(12'hFFF), 12'hFFF, 16'h7FFF, 16'h8000);

    // Per-band gains 0,0x400,0x800,0xC00,0xFFF: terms 2p -> 20478, *2048>>12 = 10239;
    // right (0x0800) terms p -> 10239, *2048>>12 = 5119.5 -> 5119
    pmix = {12'hFFF, 12'hC00, 12'h800, 12'h400, 12'h000};
    run("mixpot", rep16(16'h1000), rep16(16'h0800), pmix, 12'h800, 16'h27FF, 16'h13FF);

    // Floor rounding: +1 -> 5*4095>>12 = 4; -1 -> -20475>>12 = -5
    run("floor", rep16(16'h0001), rep16(16'hFFFF), rep12(12'h800), 12'hFFF, 16'h0004, 16'hFFFB);

    // Outputs hold between pulses
    v0 = n_vld;
    repeat (6) @(negedge clk);
    chk("hold_lft", 32'(aud_out_lft), 32'h0004);
    chk("hold_rght", 32'(aud_out_rght), 32'hFFFB);
    chk("hold_novld", 32'(n_vld - v0), 32'd1);

    // Overrun: second request three edges after acceptance is dropped
    @(negedge clk);
    band_lft = rep16(16'h1000); band_rght = rep16(16'hF000); pot = rep12(12'h800); volume = 12'hFFF;
    smpl_vld = 1'b1;
    start = cyc;
    v0 = n_vld;
    @(negedge clk);
    smpl_vld = 1'b0;
    repeat (2) @(negedge clk);
    band_lft = rep16(16'h7000); band_rght = rep16(16'h8000); pot = rep12(12'hFFF);
    smpl_vld = 1'b1;
    @(negedge clk);
    smpl_vld = 1'b0;
    chk("ovr_pulse", 32'(ovr_err), 32'd1);
    chk("ovr_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("ovr_single", 32'(ovr_err), 32'd0);
    wait_vld(c0, ok);
    chk("ovr_timeout", 32'(ok), 32'd1);
    chk("ovr_latency", 32'(c0 - start), 32'd7);
    chk("ovr_lft", 32'(aud_out_lft), 32'h4FFB);
    chk("ovr_rght", 32'(aud_out_rght), 32'hB005);
    repeat (20) @(negedge clk);
    chk("ovr_one_vld", 32'(n_vld - v0), 32'd1);

    // Back-to-back: smpl_vld held high, one result every 7 clocks
    @(negedge clk);
    band_lft = rep16(16'h1000); band_rght = rep16(16'hF000); pot = rep12(12'h800); volume = 12'hFFF;
    smpl_vld = 1'b1;
    c1 = -1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      wait_vld(c0, ok);
      chk("b2b_timeout", 32'(ok), 32'd1);
      if (k > 0) chk("b2b_interval", 32'(c0 - c1), 32'd7);
      chk("b2b_lft", 32'(aud_out_lft), 32'h4FFB);
      c1 = c0;
      if (k == 2) begin
        smpl_vld = 1'b0;
      end else begin
        @(negedge clk);
        chk("b2b_no_ovr", 32'(ovr_err), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
      end
    end
    repeat (3) @(negedge clk);

    // Reset in the middle of accumulation
    band_lft = rep16(16'h2000); band_rght = rep16(16'h2000);
    smpl_vld = 1'b1;
    @(negedge clk);
    smpl_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_lft", 32'(aud_out_lft), 32'h0);
    chk("mrst_rght", 32'(aud_out_rght), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_vld", 32'(out_vld), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v0 = n_vld;
    repeat (15) @(negedge clk);
    chk("mrst_no_vld", 32'(n_vld - v0), 32'd0);
    chk("mrst_idle", 32'(busy), 32'd0);
    run("post_rst", rep16(16'h1000), rep16(16'hF000), rep12(12'h800), 12'hFFF, 16'h4FFB, 16'hB005);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
